time_unit_counter: RTL

TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

---
 rtl/time_unit_counter_pkg.sv | 22 ++
 rtl/time_unit_counter_if.sv | 30 +++
 rtl/time_unit_counter_bcd_digit.sv | 39 +++
 rtl/time_unit_counter.sv | 113 +++++++++++
 4 files changed

// File: rtl/time_unit_counter_pkg.sv
// Shared BCD types and helpers for the time unit counter.
// Optional build macro used by this slice: TIME_UNIT_DOWN_EN (adds the dir port and down counting).
package time_unit_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic logic digit_valid(bcd_t d);
        return d <= BCD_MAX;
    endfunction

    function automatic int unsigned bcd_to_bin(bcd_t tens, bcd_t ones);
        return 32'(tens) * 32'd10 + 32'(ones);
    endfunction

    // Packed as {tens, ones}.
    function automatic logic [7:0] bin_to_bcd(int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/time_unit_counter_if.sv
// Control and count bundle of time_unit_counter; dir exists only with TIME_UNIT_DOWN_EN.
interface time_unit_counter_if;
    import time_unit_counter_pkg::*;

    logic tick;
    logic key;
    logic load;
    bcd_t load_ones;
    bcd_t load_tens;
`ifdef TIME_UNIT_DOWN_EN
    logic dir;
`endif
    bcd_t ones;
    bcd_t tens;
    logic carry;
    logic load_err;

`ifdef TIME_UNIT_DOWN_EN
    modport master (output tick, key, load, load_ones, load_tens, dir,
                    input ones, tens, carry, load_err);
    modport slave  (input tick, key, load, load_ones, load_tens, dir,
                    output ones, tens, carry, load_err);
`else
    modport master (output tick, key, load, load_ones, load_tens,
                    input ones, tens, carry, load_err);
    modport slave  (input tick, key, load, load_ones, load_tens,
                    output ones, tens, carry, load_err);
`endif

endinterface

// File: rtl/time_unit_counter_bcd_digit.sv
// Single decade digit: wraps after a programmable terminal value, with load and terminal flag.
// The dec path exists only with TIME_UNIT_DOWN_EN.
module bcd_digit
    import time_unit_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  bcd_t rst_val,
    input  logic inc,
`ifdef TIME_UNIT_DOWN_EN
    input  logic dec,
`endif
    input  bcd_t term,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t value,
    output logic at_term
);

    bcd_t value_q;

    assign at_term = (value_q == term);
    assign value   = value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= rst_val;
        end else if (load) begin
            value_q <= load_val;
        end else if (inc) begin
            value_q <= at_term ? 4'd0 : value_q + 4'd1;
`ifdef TIME_UNIT_DOWN_EN
        end else if (dec) begin
            value_q <= (value_q == 4'd0) ? term : value_q - 4'd1;
`endif
        end
    end

endmodule

// File: rtl/time_unit_counter.sv
// Two-digit BCD modulo-MODULUS counter with tick enable, hold key, preset load and wrap carry.
// Build macro TIME_UNIT_DOWN_EN adds the dir port and borrow-style down counting.
module time_unit_counter
    import time_unit_counter_pkg::*;
#(
    parameter int unsigned MODULUS   = 60,
    parameter int unsigned RESET_VAL = 0
) (
    input logic               clk,
    input logic               reset,
    time_unit_counter_if.slave bus
);

    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("time_unit_counter: MODULUS must be within 2..100");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("time_unit_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [7:0] RST_BCD  = bin_to_bcd(RESET_VAL);
    localparam logic [7:0] MAX_BCD  = bin_to_bcd(MODULUS - 1);
    localparam bcd_t       MAX_ONES = MAX_BCD[3:0];
    localparam bcd_t       MAX_TENS = MAX_BCD[7:4];

    bcd_t ones, tens;
    bcd_t ones_load_val, tens_load_val;
    logic ones_at_term, tens_at_term;
    logic load_ok, step, step_up, at_max, wrap_up, wrap, digit_load;
    logic carry_q, load_err_q;

    assign load_ok = bus.load & digit_valid(bus.load_ones) & digit_valid(bus.load_tens)
                   & (bcd_to_bin(bus.load_tens, bus.load_ones) < MODULUS);
    // Any load request, accepted or not, swallows a coincident tick.
    assign step    = bus.tick & ~bus.key & ~bus.load;
    assign at_max  = tens_at_term & (ones == MAX_ONES);

`ifdef TIME_UNIT_DOWN_EN
    logic step_dn, wrap_dn;
    assign step_up = step & ~bus.dir;
    assign step_dn = step & bus.dir;
    assign wrap_dn = step_dn & (ones == 4'd0) & (tens == 4'd0);
    assign wrap_up = step_up & at_max;
    assign wrap    = wrap_up | wrap_dn;
`else
    assign step_up = step;
    assign wrap_up = step_up & at_max;
    assign wrap    = wrap_up;
`endif

    // Wraps are applied as digit loads so the terminal digits never need to know MODULUS.
    assign digit_load = load_ok | wrap;

    always_comb begin
        ones_load_val = 4'd0;
        tens_load_val = 4'd0;
        if (load_ok) begin
            ones_load_val = bus.load_ones;
            tens_load_val = bus.load_tens;
`ifdef TIME_UNIT_DOWN_EN
        end else if (wrap_dn) begin
            ones_load_val = MAX_ONES;
            tens_load_val = MAX_TENS;
`endif
        end
    end

    bcd_digit u_ones (
        .clk      (clk),
        .reset    (reset),
        .rst_val  (RST_BCD[3:0]),
        .inc      (step_up),
`ifdef TIME_UNIT_DOWN_EN
        .dec      (step_dn),
`endif
        .term     (BCD_MAX),
        .load     (digit_load),
        .load_val (ones_load_val),
        .value    (ones),
        .at_term  (ones_at_term)
    );

    bcd_digit u_tens (
        .clk      (clk),
        .reset    (reset),
        .rst_val  (RST_BCD[7:4]),
        .inc      (step_up & ones_at_term),
`ifdef TIME_UNIT_DOWN_EN
        .dec      (step_dn & (ones == 4'd0)),
`endif
        .term     (MAX_TENS),
        .load     (digit_load),
        .load_val (tens_load_val),
        .value    (tens),
        .at_term  (tens_at_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= wrap;
            load_err_q <= bus.load & ~load_ok;
        end
    end

    assign bus.ones     = ones;
    assign bus.tens     = tens;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;

endmodule
